// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer and the planned TDM transmitter.
// FSM encoding, default frame geometry and the slot-index width helper.
package tdm_pkg;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam int DEF_LANES = 4;
    localparam int DEF_WIDTH = 1;
    localparam int DEF_IDX_W = $clog2(DEF_LANES);

    // A counter still needs one bit when there would otherwise be zero.
    function automatic int idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-LANES slot counter with clear, load-to-1 and increment controls.
// Priority is clear > load1 > inc; o_wrap flags the final slot of a frame.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int IDX_W = idx_w(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_count,
    output logic             o_wrap
);

    logic [IDX_W-1:0] r_count;

    assign o_wrap  = (r_count == IDX_W'(LANES - 1));
    assign o_count = r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= IDX_W'(1);
        end else if (i_inc) begin
            r_count <= o_wrap ? '0 : r_count + IDX_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux_4.sv
// TDM receive demultiplexer: gathers LANES slots into one frame word with
// start-of-frame alignment. Define TDM_DEMUX_ERR_CNT_EN to add err_cnt/err_clr.
module tdm_demux_4
    import tdm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   in_valid,
    input  logic                   in_sof,
    output logic                   in_ready,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       lane_strobe,
    output logic                   locked,
`ifdef TDM_DEMUX_ERR_CNT_EN
    input  logic                   err_clr,
    output logic [7:0]             err_cnt,
`endif
    output logic                   sync_err
);

    localparam int IDX_W = idx_w(LANES);

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       w_count, w_slot;
    logic                   w_wrap, w_accept;
    logic                   w_store, w_load1, w_inc, w_clr, w_resync, w_complete;
    logic [LANES*WIDTH-1:0] r_partial, r_data_out, w_frame;
    logic [LANES-1:0]       r_strobe;
    logic                   r_out_valid, r_sync_err;

    tdm_slot_counter #(.LANES(LANES), .IDX_W(IDX_W)) u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_load1 (w_load1),
        .i_inc   (w_inc),
        .o_count (w_count),
        .o_wrap  (w_wrap)
    );

    // Only the final slot can be held off: it is the one that overwrites data_out.
    assign in_ready = !(r_out_valid && !out_ready && w_wrap && (r_state == ST_COLLECT));
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HUNT;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_slot      = w_count;
        w_load1     = 1'b0;
        w_inc       = 1'b0;
        w_clr       = 1'b0;
        w_resync    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_HUNT: begin
                w_clr = 1'b1;
                if (w_accept && in_sof) begin
                    w_clr       = 1'b0;
                    w_store     = 1'b1;
                    w_slot      = '0;
                    w_load1     = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    w_store = 1'b1;
                    if (in_sof && (w_count != '0)) begin
                        w_resync = 1'b1;
                        w_slot   = '0;
                        w_load1  = 1'b1;
                    end else begin
                        w_inc      = 1'b1;
                        w_complete = w_wrap;
                    end
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    always_comb begin
        w_frame = r_partial;
        w_frame[(LANES-1)*WIDTH +: WIDTH] = data_in;
    end

    // NOTE: the partial-frame register is reset like any other flop even though
    // stale lanes are never emitted; it keeps data_out deterministic after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_partial   <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_strobe    <= '0;
            r_sync_err  <= 1'b0;
        end else begin
            r_sync_err <= w_resync;
            r_strobe   <= w_store ? (LANES'(1) << w_slot) : '0;
            if (w_store) begin
                r_partial[w_slot*WIDTH +: WIDTH] <= data_in;
            end
            if (w_complete) begin
                r_data_out  <= w_frame;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign data_out    = r_data_out;
    assign out_valid   = r_out_valid;
    assign lane_strobe = r_strobe;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == ST_COLLECT);

`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // A clear coinciding with a pulse keeps that pulse, so the result is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= {7'd0, r_sync_err};
        end else if (r_sync_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_tdm_demux_4.sv
// Self-checking bench for tdm_demux_4 (WIDTH=1, LANES=4): directed plan steps
// plus random traffic against a queue-based frame model.
module tb_tdm_demux_4;

    localparam int W  = 1;
    localparam int L  = 4;
    localparam int LW = L * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic [LW-1:0] data_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [L-1:0]  lane_strobe;
    logic          locked;
    logic          sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic          err_clr = 1'b0;
    logic [7:0]    err_cnt;
`endif

    tdm_demux_4 #(.WIDTH(W), .LANES(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .lane_strobe (lane_strobe),
        .locked      (locked),
`ifdef TDM_DEMUX_ERR_CNT_EN
        .err_clr     (err_clr),
        .err_cnt     (err_cnt),
`endif
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: aligned flag, slots gathered so far, emitted frame.
    bit            m_locked;
    logic [W-1:0]  m_q[$];
    logic          m_ov;
    logic [LW-1:0] m_od;
    logic [L-1:0]  m_strobe;
    logic          m_err;
    int            m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_q.delete();
        m_ov     = 1'b0;
        m_od     = '0;
        m_strobe = '0;
        m_err    = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_od));
        chk({tag, ".lane_strobe"}, 32'(lane_strobe), 32'(m_strobe));
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
        chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_err));
`ifdef TDM_DEMUX_ERR_CNT_EN
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
`endif
    endtask

    // One clock: drive at the falling edge, check in_ready before the rising
    // edge, advance the model, then check registered outputs just after it.
    task automatic cycle(input logic v, input logic sof, input logic [W-1:0] d,
                         input logic ordy, input string tag);
        bit            acc, done, clr;
        logic [LW-1:0] frame;
        in_valid  = v;
        in_sof    = sof;
        data_in   = d;
        out_ready = ordy;
        clr = 1'b0;
`ifdef TDM_DEMUX_ERR_CNT_EN
        clr = err_clr;
`endif
        #1;
        acc = !(m_ov && !ordy && m_locked && (m_q.size() == L - 1));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(acc));
        acc  = acc && v;
        done = 1'b0;
        frame = '0;
        if (clr)                    m_cnt = m_err ? 1 : 0;
        else if (m_err && m_cnt < 255) m_cnt++;
        m_strobe = '0;
        m_err    = 1'b0;
        if (acc) begin
            if (!m_locked) begin
                if (sof) begin
                    m_locked = 1'b1;
                    m_q = {d};
                    m_strobe = 1;
                end
            end else if (sof && m_q.size() != 0) begin
                m_q = {d};
                m_err = 1'b1;
                m_strobe = 1;
            end else begin
                m_strobe = L'(1) << m_q.size();
                m_q.push_back(d);
                if (m_q.size() == L) begin
                    for (int k = 0; k < L; k++) frame[k*W +: W] = m_q[k];
                    m_q.delete();
                    done = 1'b1;
                end
            end
        end
        if (done) begin
            m_ov = 1'b1;
            m_od = frame;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] frames [3];
    logic [3:0] fv;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Plan 1: aligned frame 1,0,1,1.
        cycle(1, 1, 1, 1, "t1.b0");
        chk("t1.strobe0", 32'(lane_strobe), 32'b0001);
        cycle(1, 0, 0, 1, "t1.b1");
        chk("t1.strobe1", 32'(lane_strobe), 32'b0010);
        cycle(1, 0, 1, 1, "t1.b2");
        cycle(1, 0, 1, 1, "t1.b3");
        chk("t1.frame", 32'(data_out), 32'b1101);
        chk("t1.valid", 32'(out_valid), 32'd1);
        chk("t1.locked", 32'(locked), 32'd1);
        cycle(0, 0, 0, 1, "t1.idle");

        // Plan 2: unaligned beats discarded in HUNT.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, 1, "t2.hunt");
            chk("t2.hunt_strobe", 32'(lane_strobe), 32'd0);
        end
        cycle(1, 1, 0, 1, "t2.b0");
        cycle(1, 0, 1, 1, "t2.b1");
        cycle(1, 0, 0, 1, "t2.b2");
        cycle(1, 0, 1, 1, "t2.b3");
        chk("t2.frame", 32'(data_out), 32'b1010);

        // Plan 3: resync at slot 2 of the following frame.
        cycle(1, 1, 1, 1, "t3.a0");
        cycle(1, 0, 0, 1, "t3.a1");
        cycle(1, 0, 0, 1, "t3.a2");
        cycle(1, 0, 1, 1, "t3.a3");
        chk("t3.frame_a", 32'(data_out), 32'b1001);
        cycle(1, 1, 1, 1, "t3.b0");
        cycle(1, 0, 1, 1, "t3.b1");
        cycle(1, 1, 0, 1, "t3.sof_mid");
        chk("t3.sync_err_pulse", 32'(sync_err), 32'd1);
        cycle(1, 0, 1, 1, "t3.c1");
        chk("t3.sync_err_low", 32'(sync_err), 32'd0);
        cycle(1, 0, 1, 1, "t3.c2");
        cycle(1, 0, 0, 1, "t3.c3");
        chk("t3.frame_resync", 32'(data_out), 32'b0110);
        cycle(0, 0, 0, 1, "t3.idle");

        // Plan 4: backpressure on the final slot, then bubble-free reload.
        cycle(1, 1, 0, 0, "t4.a0");
        cycle(1, 0, 1, 0, "t4.a1");
        cycle(1, 0, 1, 0, "t4.a2");
        cycle(1, 0, 0, 0, "t4.a3");
        cycle(1, 1, 1, 0, "t4.b0");
        cycle(1, 0, 1, 0, "t4.b1");
        cycle(1, 0, 1, 0, "t4.b2");
        cycle(1, 0, 1, 0, "t4.b3_held");
        chk("t4.held_data", 32'(data_out), 32'b0110);
        chk("t4.held_valid", 32'(out_valid), 32'd1);
        cycle(1, 0, 1, 1, "t4.b3_go");
        chk("t4.no_bubble", 32'(out_valid), 32'd1);
        chk("t4.new_frame", 32'(data_out), 32'b1111);
        cycle(0, 0, 0, 1, "t4.idle");

        // Plan 5: back-to-back frames with in_valid toggling.
        frames[0] = 4'hF;
        frames[1] = 4'h0;
        frames[2] = 4'hA;
        for (int f = 0; f < 3; f++) begin
            fv = frames[f];
            for (int s = 0; s < L; s++) begin
                cycle(1, (s == 0), fv[s], 1, "t5.beat");
                if (s == L - 1) chk("t5.frame", 32'(data_out), 32'(fv));
                cycle(0, 0, 0, 1, "t5.gap");
            end
        end
        chk("t5.no_err", 32'(sync_err), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 8) == 0, W'($urandom),
                  ($urandom % 3) != 0, "rnd");
        end

`ifdef TDM_DEMUX_ERR_CNT_EN
        for (int i = 0; i < 301; i++) cycle(1, 1, W'($urandom), 1, "ec.resync");
        cycle(0, 0, 0, 1, "ec.idle0");
        cycle(0, 0, 0, 1, "ec.idle1");
        chk("ec.saturate", 32'(err_cnt), 32'd255);
        err_clr = 1'b1;
        cycle(0, 0, 0, 1, "ec.clr");
        err_clr = 1'b0;
        chk("ec.cleared", 32'(err_cnt), 32'd0);
`endif

        // Reset in the middle of a frame while a frame is pending.
        cycle(0, 0, 0, 1, "mr.idle");
        cycle(1, 1, 1, 0, "mr.a0");
        cycle(1, 0, 0, 0, "mr.a1");
        cycle(1, 0, 1, 0, "mr.a2");
        cycle(1, 0, 1, 0, "mr.a3");
        cycle(1, 1, 0, 0, "mr.b0");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr.out_valid", 32'(out_valid), 32'd0);
        chk("mr.data_out", 32'(data_out), 32'd0);
        chk("mr.locked", 32'(locked), 32'd0);
        chk("mr.strobe", 32'(lane_strobe), 32'd0);
        chk("mr.sync_err", 32'(sync_err), 32'd0);
        @(negedge clk);
        do_reset();
        cycle(1, 0, 1, 1, "mr.hunt");
        cycle(1, 1, 0, 1, "mr.b0");
        cycle(1, 0, 0, 1, "mr.b1");
        cycle(1, 0, 1, 1, "mr.b2");
        cycle(1, 0, 1, 1, "mr.b3");
        chk("mr.frame", 32'(data_out), 32'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
